// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: blinks ULED with CMD_NUM blinks of CMD_ON/CMD_OFF ticks; DONE pulses NUM*(ON+OFF)*PRESCALE cycles after accept.
// Single command in flight: CMD_READY is low from accept until the cycle after DONE. `define LED_SEQ_ABORT_EN adds an ABORT input.
module led_seq_ctrl #(
   parameter int PRESCALE = 4,
   parameter int CNT_W    = 8,
   parameter int NUM_W    = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [CNT_W-1:0] CMD_ON,
   input  logic [CNT_W-1:0] CMD_OFF,
   input  logic [NUM_W-1:0] CMD_NUM,
`ifdef LED_SEQ_ABORT_EN
   input  logic             ABORT,
`endif
   output logic             ULED,
   output logic             BUSY,
   output logic             DONE
);
   localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_FIN} state_t;

   state_t           state_q, state_d;
   logic             uled_q, uled_d;
   logic             done_q, done_d;
   logic             rdy_q, rdy_d;
   logic [CNT_W-1:0] on_q, on_d;
   logic [CNT_W-1:0] off_q, off_d;
   logic [CNT_W-1:0] ph_q, ph_d;
   logic [NUM_W-1:0] rem_q, rem_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic [CNT_W-1:0] ph_inc;
   logic             tick;
   logic             accept;
   logic             abort;

   always_comb begin
`ifdef LED_SEQ_ABORT_EN
      abort = ABORT;
`else
      abort = 1'b0;
`endif
      tick    = (psc_q == PSC_MAX);
      accept  = CMD_VALID && rdy_q;
      ph_inc  = ph_q + 1'b1;
      state_d = state_q;
      uled_d  = uled_q;
      done_d  = 1'b0;
      rdy_d   = rdy_q;
      on_d    = on_q;
      off_d   = off_q;
      ph_d    = ph_q;
      rem_d   = rem_q;
      psc_d   = psc_q;

      case (state_q)
         S_IDLE: begin
            rdy_d = 1'b1;
            if (accept) begin
               rdy_d = 1'b0;
               on_d  = CMD_ON;
               off_d = CMD_OFF;
               rem_d = CMD_NUM;
               psc_d = '0;
               ph_d  = '0;
               if (CMD_NUM == '0 || CMD_ON == '0) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ON;
                  uled_d  = 1'b1;
               end
            end
         end
         S_ON: begin
            psc_d = tick ? '0 : psc_q + 1'b1;
            if (tick) ph_d = ph_inc;
            if (abort) begin
               state_d = S_FIN;
               uled_d  = 1'b0;
               done_d  = 1'b1;
            end else if (tick && ph_inc == on_q) begin
               ph_d  = '0;
               rem_d = rem_q - 1'b1;
               if (off_q != '0) begin
                  state_d = S_OFF;
                  uled_d  = 1'b0;
               end else if (rem_q == NUM_W'(1)) begin
                  state_d = S_FIN;
                  uled_d  = 1'b0;
                  done_d  = 1'b1;
               end
               // zero off-time with blinks left: stay ON so the LED does not glitch low
            end
         end
         S_OFF: begin
            psc_d = tick ? '0 : psc_q + 1'b1;
            if (tick) ph_d = ph_inc;
            if (abort) begin
               state_d = S_FIN;
               done_d  = 1'b1;
            end else if (tick && ph_inc == off_q) begin
               ph_d = '0;
               if (rem_q != '0) begin
                  state_d = S_ON;
                  uled_d  = 1'b1;
               end else begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
            psc_d   = '0;
            ph_d    = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         uled_q  <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
         on_q    <= '0;
         off_q   <= '0;
         ph_q    <= '0;
         rem_q   <= '0;
         psc_q   <= '0;
      end else begin
         state_q <= state_d;
         uled_q  <= uled_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
         on_q    <= on_d;
         off_q   <= off_d;
         ph_q    <= ph_d;
         rem_q   <= rem_d;
         psc_q   <= psc_d;
      end
   end

   assign ULED      = uled_q;
   assign DONE      = done_q;
   assign CMD_READY = rdy_q;
   assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: the driver pushes an expected LED profile per accepted command,
// the monitor measures ULED/DONE/BUSY after each accept and compares when DONE appears.
`timescale 1ns/1ps
module tb_led_seq_ctrl;
   localparam int P     = 4;
   localparam int CNT_W = 8;
   localparam int NUM_W = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             CMD_VALID = 1'b0;
   logic             CMD_READY;
   logic [CNT_W-1:0] CMD_ON = '0;
   logic [CNT_W-1:0] CMD_OFF = '0;
   logic [NUM_W-1:0] CMD_NUM = '0;
   logic             ABORT = 1'b0;
   logic             ULED, BUSY, DONE;

   int total = 0;
   int bad   = 0;

   int exp_lat_q[$];
   int exp_hi_q[$];
   int exp_sum_q[$];
   int exp_rise_q[$];

   bit active = 1'b0;
   bit chk_rdy = 1'b0;
   bit prev_led = 1'b0;
   int idx, hi, hsum, rises, busy_err;

   always #5 CLK = ~CLK;

   led_seq_ctrl #(.PRESCALE(P), .CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_ON(CMD_ON), .CMD_OFF(CMD_OFF), .CMD_NUM(CMD_NUM),
`ifdef LED_SEQ_ABORT_EN
      .ABORT(ABORT),
`endif
      .ULED(ULED), .BUSY(BUSY), .DONE(DONE)
   );

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: blink b occupies cycles b*(on+off)*P .. and is lit for the first on*P of them.
   task automatic push_model(input int on, input int off, input int num);
      int lat, nhi, s, r, base;
      nhi = 0; s = 0; r = 0; lat = 0;
      if (num != 0 && on != 0) begin
         lat = num * (on + off) * P;
         for (int b = 0; b < num; b++) begin
            base = b * (on + off) * P;
            for (int j = 0; j < on * P; j++) begin
               nhi++;
               s += base + j;
            end
         end
         r = (off == 0) ? 1 : num;
      end
      exp_lat_q.push_back(lat);
      exp_hi_q.push_back(nhi);
      exp_sum_q.push_back(s);
      exp_rise_q.push_back(r);
   endtask

   task automatic push_raw(input int lat, input int nhi, input int s, input int r);
      exp_lat_q.push_back(lat);
      exp_hi_q.push_back(nhi);
      exp_sum_q.push_back(s);
      exp_rise_q.push_back(r);
   endtask

   always @(negedge CLK) begin
      if (!RST) begin
         active  = 1'b0;
         chk_rdy = 1'b0;
      end else begin
         if (chk_rdy) begin
            check("ready_after_done", int'(CMD_READY), 1);
            chk_rdy = 1'b0;
         end
         if (active) begin
            if (DONE) begin
               if (exp_lat_q.size() == 0) begin
                  check("done_without_expectation", exp_lat_q.size(), 1);
               end else begin
                  check("latency", idx, exp_lat_q.pop_front());
                  check("led_high_cycles", hi, exp_hi_q.pop_front());
                  check("led_timing_sum", hsum, exp_sum_q.pop_front());
                  check("led_rises", rises, exp_rise_q.pop_front());
                  check("busy_during_seq", busy_err, 0);
                  check("led_at_done", int'(ULED), 0);
                  check("busy_at_done", int'(BUSY), 1);
               end
               active  = 1'b0;
               chk_rdy = 1'b1;
            end else begin
               if (ULED) begin
                  hi++;
                  hsum += idx;
                  if (!prev_led) rises++;
               end
               if (!BUSY) busy_err++;
               prev_led = ULED;
               idx++;
            end
         end else if (DONE) begin
            check("spurious_done", int'(DONE), 0);
         end
         if (CMD_VALID && CMD_READY) begin
            active = 1'b1;
            idx = 0; hi = 0; hsum = 0; rises = 0; busy_err = 0;
            prev_led = 1'b0;
         end
      end
   end

   task automatic send(input int on, input int off, input int num,
                       input bit scramble, input bit keep_valid, input bit do_abort);
      int guard;
      guard = 0;
      CMD_VALID = 1'b1;
      CMD_ON  = CNT_W'(on);
      CMD_OFF = CNT_W'(off);
      CMD_NUM = NUM_W'(num);
      forever begin
         @(negedge CLK);
         if (CMD_READY) break;
         if (scramble) begin
            CMD_ON  = CNT_W'($urandom);
            CMD_OFF = CNT_W'($urandom);
            CMD_NUM = NUM_W'($urandom);
         end
         guard++;
         if (guard > 40000) begin
            check("accept_timeout", int'(CMD_READY), 1);
            CMD_VALID = 1'b0;
            return;
         end
      end
      CMD_ON  = CNT_W'(on);
      CMD_OFF = CNT_W'(off);
      CMD_NUM = NUM_W'(num);
      if (do_abort) push_raw(3, 3, 0 + 1 + 2, 1);
      else          push_model(on, off, num);
      @(posedge CLK); #1;
      if (!keep_valid) CMD_VALID = 1'b0;
      if (do_abort) begin
         repeat (2) begin @(posedge CLK); #1; end
         ABORT = 1'b1;
         @(posedge CLK); #1;
         ABORT = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((exp_lat_q.size() != 0 || active) && guard < 40000) begin
         @(posedge CLK);
         guard++;
      end
      if (guard >= 40000) check("idle_timeout", exp_lat_q.size(), 0);
      repeat (3) @(posedge CLK);
      #1;
   endtask

   initial begin
      repeat (100) @(posedge CLK);
      @(negedge CLK);
      check("rst_uled", int'(ULED), 0);
      check("rst_done", int'(DONE), 0);
      check("rst_busy", int'(BUSY), 0);
      check("rst_ready", int'(CMD_READY), 0);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      check("ready_before_first_edge", int'(CMD_READY), 0);
      @(negedge CLK);
      check("ready_after_first_edge", int'(CMD_READY), 1);
      @(posedge CLK); #1;

      send(3, 2, 0, 0, 0, 0);
      send(0, 3, 2, 0, 0, 0);
      send(2, 3, 2, 0, 0, 0);
      send(1, 0, 3, 0, 0, 0);
      send(255, 0, 15, 0, 0, 0);
      send(255, 255, 1, 0, 0, 0);
      send(2, 1, 2, 0, 1, 0);
      send(1, 2, 3, 1, 1, 0);
      send(3, 0, 2, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         send(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
      end
      CMD_VALID = 1'b0;
`ifdef LED_SEQ_ABORT_EN
      send(2, 3, 2, 0, 0, 1);
`endif
      wait_idle();

      send(5, 5, 2, 0, 0, 0);
      repeat (6) @(posedge CLK);
      #3;
      RST = 1'b0;
      #1;
      check("midseq_rst_uled", int'(ULED), 0);
      check("midseq_rst_busy", int'(BUSY), 0);
      check("midseq_rst_ready", int'(CMD_READY), 0);
      exp_lat_q.delete();
      exp_hi_q.delete();
      exp_sum_q.delete();
      exp_rise_q.delete();
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      repeat (40) @(posedge CLK);
      #1;
      send(1, 1, 1, 0, 0, 0);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
